// File: rtl/audio_pwm_out.sv
// audio_pwm_out: sample consumer for the board audio jack.
//
// Accepts 8-bit two's-complement samples over a valid/ready handshake and stores them
// as offset binary in a small FIFO. One sample is released per sample tick
// (every SAMPLE_DIV clocks) and rendered as a 256-clock-period PWM stream.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset; has priority over everything
//   en           1 = audio path running, 0 = flush FIFO, hold counters, mute
//   sample_in    signed sample, -128..127
//   sample_valid sample_in holds a sample to transfer
//   sample_ready block can accept a sample this cycle
//   pwm_out      registered PWM bit-stream
//   aud_sd       amplifier enable, en delayed by one clock
//   underrun     sticky: a sample tick found the FIFO empty
//   fifo_level   FIFO occupancy, 0..FIFO_DEPTH
module audio_pwm_out #(
  parameter int unsigned SAMPLE_DIV = 2268,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       pwm_out,
  output logic       aud_sd,
  output logic       underrun,
  output logic [4:0] fifo_level
);

  localparam int unsigned TickW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One extra pointer bit tells full from empty when the address bits match.
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
  localparam logic [7:0]       MidScale = 8'd128;

  // State
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       cur_level_q, cur_level_d;
  logic [7:0]       duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             aud_sd_q, aud_sd_d;
  logic             underrun_q, underrun_d;

  // Decoded control
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            tick;
  logic [7:0]      head;
  logic [PtrW-1:0] ptr_diff;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    // Gated by reset so nothing looks acceptable while the block is held in reset.
    sample_ready = en & ~full & ~reset;
    push     = sample_valid & sample_ready;
    tick     = en & (tick_cnt_q == TickLast);
    // Pop decision uses the pre-push state: a push into an empty FIFO on a tick
    // still counts as an underrun and the new sample becomes the head.
    pop      = tick & ~empty;
    head     = mem_q[rd_ptr_q[AddrW-1:0]];
    ptr_diff = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tick_cnt_d  = tick_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    cur_level_d = cur_level_q;
    duty_d      = duty_q;
    pwm_d       = pwm_q;
    underrun_d  = underrun_q;
    aud_sd_d    = en;

    if (!en) begin
      // Muted: flush, park counters at zero, return to mid-scale silence.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      tick_cnt_d  = '0;
      pwm_cnt_d   = '0;
      cur_level_d = MidScale;
      duty_d      = MidScale;
      pwm_d       = 1'b0;
      underrun_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

      if (tick) begin
        if (empty) begin
          cur_level_d = MidScale;
          underrun_d  = 1'b1;
        end else begin
          cur_level_d = head;
        end
      end

      pwm_cnt_d = pwm_cnt_q + 8'd1;
      // Duty only reloads on the last count of a period, so a period never glitches.
      if (pwm_cnt_q == 8'hFF) begin
        duty_d = cur_level_q;
      end
      pwm_d = (pwm_cnt_q < duty_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tick_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      cur_level_q <= MidScale;
      duty_q      <= MidScale;
      pwm_q       <= 1'b0;
      aud_sd_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      cur_level_q <= cur_level_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      aud_sd_q    <= aud_sd_d;
      underrun_q  <= underrun_d;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  // Samples are stored as offset binary (-128 -> 0, 0 -> 128, 127 -> 255).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= sample_in ^ 8'h80;
    end
  end

  assign pwm_out    = pwm_q;
  assign aud_sd     = aud_sd_q;
  assign underrun   = underrun_q;
  assign fifo_level = 5'(ptr_diff);

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out with SAMPLE_DIV=16, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_audio_pwm_out;

  localparam int SampleDiv = 16;
  localparam int FifoDepth = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       pwm_out;
  logic       aud_sd;
  logic       underrun;
  logic [4:0] fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  // Clock edges since the last reset/mute; tick edges are multiples of SampleDiv.
  int edge_cnt = 0;

  typedef struct {
    logic [7:0] sample;
    int         high_clks;
  } conv_vec_t;

  conv_vec_t conv_tbl[6];

  always #5 clk = ~clk;

  audio_pwm_out #(
    .SAMPLE_DIV(SampleDiv),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out     (pwm_out),
    .aud_sd      (aud_sd),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  always @(posedge clk) begin
    if (reset || !en) edge_cnt <= 0;
    else              edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Return at the falling edge just after the next tick edge (pop visible).
  task automatic wait_after_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edge_cnt % SampleDiv) != 0 && n < 64);
    if ((edge_cnt % SampleDiv) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_wait: got no tick, expected one within 64 clks");
    end
  endtask

  // Return at the falling edge of the tick cycle itself (next rising edge is the tick).
  task automatic wait_tick_cycle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edge_cnt % SampleDiv) != SampleDiv - 1 && n < 64);
    if ((edge_cnt % SampleDiv) != SampleDiv - 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_cycle_wait: got no tick cycle, expected one within 64 clks");
    end
  endtask

  task automatic push_one(input logic [7:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // One-clock mute: flush and restart counting from zero.
  task automatic mute_pulse();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] val;
    logic [7:0] exp_lvl;
    int         accepted;
    int         cnt;
    bit         took;

    conv_tbl[0] = '{sample: 8'h80, high_clks: 0};    // -128
    conv_tbl[1] = '{sample: 8'h00, high_clks: 128};  // 0
    conv_tbl[2] = '{sample: 8'h7F, high_clks: 255};  // 127
    conv_tbl[3] = '{sample: 8'hFF, high_clks: 127};  // -1
    conv_tbl[4] = '{sample: 8'h40, high_clks: 192};  // 64
    conv_tbl[5] = '{sample: 8'hC0, high_clks: 64};   // -64

    // Reset held 3 clks with en=1
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_aud_sd", aud_sd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_sample_ready", sample_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_aud_sd", aud_sd, 1);
    check("rel_sample_ready", sample_ready, 1);

    // Underrun: one sample, then silence
    push_one(8'h40);
    check("ur_level_after_push", fifo_level, 1);
    wait_after_tick();
    check("ur_first_pop", dut.cur_level_q, 8'hC0);
    check("ur_no_underrun_yet", underrun, 0);
    check("ur_level_drained", fifo_level, 0);
    wait_after_tick();
    check("ur_silence", dut.cur_level_q, 8'd128);
    check("ur_set", underrun, 1);
    push_one(8'h00);
    check("ur_sticky", underrun, 1);
    check("ur_level_new_push", fifo_level, 1);

    // Push on the tick cycle, FIFO empty then at level 2
    mute_pulse();
    check("mute_clears_underrun", underrun, 0);
    wait_tick_cycle();
    sample_in    = 8'h10;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("sim_empty_underrun", underrun, 1);
    check("sim_empty_level", fifo_level, 1);
    check("sim_empty_cur", dut.cur_level_q, 8'd128);
    wait_after_tick();
    check("sim_plays_0x90", dut.cur_level_q, 8'h90);
    check("sim_drained", fifo_level, 0);
    push_one(8'h01);
    push_one(8'h02);
    check("sim_level2", fifo_level, 2);
    wait_tick_cycle();
    sample_in    = 8'h03;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("sim_level_unchanged", fifo_level, 2);
    check("sim_pop_0x81", dut.cur_level_q, 8'h81);
    wait_after_tick();
    check("sim_pop_0x82", dut.cur_level_q, 8'h82);
    wait_after_tick();
    check("sim_pop_0x83", dut.cur_level_q, 8'h83);

    // Mid-operation mute with 3 entries queued, then reset with en=1
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    check("mute_pre_level", fifo_level, 3);
    check("mute_pre_underrun", underrun, 1);
    check("mute_pre_aud_sd", aud_sd, 1);
    en = 1'b0;
    @(negedge clk);
    check("mute_level", fifo_level, 0);
    check("mute_pwm_out", pwm_out, 0);
    check("mute_underrun", underrun, 0);
    check("mute_aud_sd", aud_sd, 0);
    check("mute_ready", sample_ready, 0);
    en    = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_en_aud_sd", aud_sd, 0);
    check("rst_en_pwm_out", pwm_out, 0);
    check("rst_en_level", fifo_level, 0);
    check("rst_en_ready", sample_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // Backpressure with sample_valid held high; scoreboard of offset-binary levels
    mute_pulse();
    val          = 8'h20;
    sample_in    = val;
    sample_valid = 1'b1;
    accepted     = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      took = sample_ready;
      if (took) begin
        q.push_back(val ^ 8'h80);
        accepted++;
      end
      @(negedge clk);
      if (took) begin
        val       = val + 8'd1;
        sample_in = val;
      end
      if ((edge_cnt % SampleDiv) == 0) begin
        if (q.size() > 0) begin
          exp_lvl = q.pop_front();
          check("bp_pop_order", dut.cur_level_q, exp_lvl);
        end else begin
          check("bp_unexpected_empty", underrun, 0);
        end
      end
      check("bp_level", fifo_level, q.size());
      check("bp_ready", sample_ready, (q.size() < FifoDepth) ? 1 : 0);
    end
    sample_valid = 1'b0;
    // 4 to fill, then one per tick at edges 16..96
    check("bp_accepted", accepted, 10);
    check("bp_no_underrun", underrun, 0);

    // Conversion: keep the FIFO fed with one value; once duty has settled
    // (well within 600 clks), any 256-clk window holds exactly duty high clks.
    mute_pulse();
    for (int v = 0; v < 6; v++) begin
      sample_in    = conv_tbl[v].sample;
      sample_valid = 1'b1;
      repeat (600) @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        if (pwm_out) cnt++;
      end
      check($sformatf("conv_high_%02h", conv_tbl[v].sample), cnt, conv_tbl[v].high_clks);
    end
    sample_valid = 1'b0;
    check("conv_no_underrun", underrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
